pot_scan_sched: RTL and testbench

//  Sequencer and arbiter for the shared A2D SPI interface. Round-robins conversions over the six

---
 rtl/pot_scan_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_pot_scan_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sched.sv
// pot_scan_sched: A2D sequencer; round-robin pot scan plus one-shot aux conversions.
// Ports: clk/rst_n, scan_en; strt_cnv/chnnl/cnv_cmplt/res to A2D_intf;
//   aux_req/aux_ch/aux_busy/aux_vld/aux_res; six *_pot results; scan_done; cnv_err.
//   Build option: define POT_FILTER_EN to average each new pot sample with the old.
module pot_scan_sched #(
  parameter int TIMEOUT = 4095,
  parameter int GAP     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic        aux_req,
  input  logic [2:0]  aux_ch,
  output logic        aux_busy,
  output logic        aux_vld,
  output logic [11:0] aux_res,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] VOL_pot,
  output logic        scan_done,
  output logic        cnv_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_GAP
  } state_t;

  state_t state;
  state_t nxt;

  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [2:0]    idx;
  logic [2:0]    aux_chq;
  logic          aux_pend;
  logic          aux_act;
  logic          aux_pri;
  logic          grant_aux;
  logic          grant_scan;
  logic          store;
  logic          timeout;
  logic [11:0]   pot_q [6];
  logic [11:0]   pot_nxt;

  function automatic logic [2:0] chan_of(
    input logic [2:0] i
  );
    logic [2:0] c;
    unique case (i)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      3'd5:    c = 3'd7;
      default: c = 3'd1;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Aux goes first only when it has priority or scan is off.
  always_comb begin
    nxt        = state;
    grant_aux  = 1'b0;
    grant_scan = 1'b0;
    store      = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (aux_pend && (aux_pri || !scan_en)) begin
          grant_aux = 1'b1;
          nxt       = S_START;
        end else if (scan_en) begin
          grant_scan = 1'b1;
          nxt        = S_START;
        end
      end
      S_START: nxt = S_WAIT;
      S_WAIT: begin
        if (cnv_cmplt) begin
          store = 1'b1;
          nxt   = S_STORE;
        end else if (tcnt == TLAST) begin
          timeout = 1'b1;
          nxt     = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_STORE: nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP: begin
        if (gcnt == GLAST) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign strt_cnv = (state == S_START);

`ifdef POT_FILTER_EN
  logic [5:0]  pot_vld;
  logic [11:0] cur_pot;
  logic        cur_vld;
  logic [12:0] sum;

  always_comb begin
    cur_pot = '0;
    cur_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) begin
        cur_pot = pot_q[i];
        cur_vld = pot_vld[i];
      end
    end
    // round half up; first sample after reset is taken as-is
    sum     = {1'b0, cur_pot} + {1'b0, res} + 13'd1;
    pot_nxt = cur_vld ? sum[12:1] : res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pot_vld <= '0;
    end else if (store && !aux_act) begin
      for (int i = 0; i < 6; i++) begin
        if (idx == 3'(i)) pot_vld[i] <= 1'b1;
      end
    end
  end
`else
  assign pot_nxt = res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      gcnt      <= '0;
      idx       <= '0;
      chnnl     <= '0;
      aux_chq   <= '0;
      aux_pend  <= 1'b0;
      aux_act   <= 1'b0;
      aux_pri   <= 1'b0;
      aux_busy  <= 1'b0;
      aux_vld   <= 1'b0;
      aux_res   <= '0;
      scan_done <= 1'b0;
      cnv_err   <= 1'b0;
      for (int i = 0; i < 6; i++) pot_q[i] <= '0;
    end else begin
      aux_vld   <= 1'b0;
      scan_done <= 1'b0;
      tcnt      <= (state == S_WAIT) ? tcnt + 1'b1 : '0;
      gcnt      <= (state == S_GAP) ? gcnt + 1'b1 : '0;

      // single-entry request slot; requests while busy are dropped
      if (aux_req && !aux_busy) begin
        aux_busy <= 1'b1;
        aux_pend <= 1'b1;
        aux_chq  <= aux_ch;
      end

      if (grant_aux) begin
        aux_pend <= 1'b0;
        aux_act  <= 1'b1;
        aux_pri  <= 1'b0;
        chnnl    <= aux_chq;
      end

      if (grant_scan) begin
        aux_act <= 1'b0;
        chnnl   <= chan_of(idx);
      end

      if (store || timeout) begin
        if (aux_act) begin
          aux_busy <= 1'b0;
          if (store) begin
            aux_res <= res;
            aux_vld <= 1'b1;
          end
        end else begin
          aux_pri <= 1'b1;
          if (store) begin
            for (int i = 0; i < 6; i++) begin
              if (idx == 3'(i)) pot_q[i] <= pot_nxt;
            end
          end
          if (idx == 3'd5) begin
            idx       <= '0;
            scan_done <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
          end
        end
      end

      if (timeout) cnv_err <= 1'b1;
    end
  end

  assign LP_pot  = pot_q[0];
  assign B1_pot  = pot_q[1];
  assign B2_pot  = pot_q[2];
  assign B3_pot  = pot_q[3];
  assign HP_pot  = pot_q[4];
  assign VOL_pot = pot_q[5];

endmodule

// File: tb/tb_pot_scan_sched.sv
// tb_pot_scan_sched: scoreboard bench for pot_scan_sched with an A2D model.
// Expected channels/aux results are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_pot_scan_sched;

  localparam int TIMEOUT = 4095;
  localparam int GAPC    = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        aux_req = 1'b0;
  logic [2:0]  aux_ch = '0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        aux_busy;
  logic        aux_vld;
  logic [11:0] aux_res;
  logic [11:0] LP_pot, B1_pot, B2_pot;
  logic [11:0] B3_pot, HP_pot, VOL_pot;
  logic        scan_done;
  logic        cnv_err;

  pot_scan_sched #(
    .TIMEOUT(TIMEOUT),
    .GAP    (GAPC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .aux_req  (aux_req),
    .aux_ch   (aux_ch),
    .aux_busy (aux_busy),
    .aux_vld  (aux_vld),
    .aux_res  (aux_res),
    .LP_pot   (LP_pot),
    .B1_pot   (B1_pot),
    .B2_pot   (B2_pot),
    .B3_pot   (B3_pot),
    .HP_pot   (HP_pot),
    .VOL_pot  (VOL_pot),
    .scan_done(scan_done),
    .cnv_err  (cnv_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int st_cnt  = 0;
  int sd_cnt  = 0;
  int av_cnt  = 0;

  logic [2:0]  ch_q [$];
  logic [11:0] aux_q [$];
  logic [11:0] lp_q [$];
  logic        hold_on = 1'b0;
  logic [2:0]  hold_ch = '0;
  logic [11:0] res_add = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [11:0] filt(input logic [11:0] old_v,
                                       input logic [11:0] new_v);
`ifdef POT_FILTER_EN
    logic [12:0] s;
    s = {1'b0, old_v} + {1'b0, new_v} + 13'd1;
    return s[12:1];
`else
    return new_v + 12'd0 * old_v;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_st(input int tgt, input int budget,
                         input string nm);
    int n = 0;
    while (st_cnt < tgt && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(st_cnt >= tgt), 1);
  endtask

  task automatic wait_sd(input int tgt, input int budget,
                         input string nm);
    int n = 0;
    while (sd_cnt < tgt && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(sd_cnt >= tgt), 1);
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (strt_cnv) begin
      st_cnt++;
      if (ch_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strt: chnnl=%0d, none queued",
                 chnnl);
      end else begin
        chk("chnnl", 32'(chnnl), 32'(ch_q.pop_front()));
      end
    end
    if (aux_vld) begin
      av_cnt++;
      if (aux_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_aux_vld: aux_res=0x%0h",
                 aux_res);
      end else begin
        chk("aux_res", 32'(aux_res), 32'(aux_q.pop_front()));
      end
    end
    if (scan_done) sd_cnt++;
  end

  // A2D model: answers 40 cycles after strt_cnv, aborts on reset
  initial begin : a2d
    logic [2:0]  ch;
    logic [11:0] r;
    logic        bad;
    logic        abort;
    int          n;
    forever begin
      @(negedge clk);
      if (rst_n && strt_cnv) begin
        ch    = chnnl;
        bad   = 1'b0;
        abort = 1'b0;
        if (hold_on && ch == hold_ch) begin
          n = 0;
          while (!cnv_err && n < 6000) begin
            @(negedge clk);
            n++;
            if (strt_cnv) bad = 1'b1;
          end
          chk("timeout_latency",
              32'(n >= TIMEOUT + 1 && n <= TIMEOUT + 2), 1);
          repeat (3) @(negedge clk);
          @(posedge clk);
          #1;
          cnv_cmplt = 1'b1;
          res       = 12'hBAD;
          @(posedge clk);
          #1;
          cnv_cmplt = 1'b0;
        end else begin
          for (int i = 0; i < 40 && !abort; i++) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
            if (strt_cnv) bad = 1'b1;
          end
          if (!abort) begin
            if (ch == 3'd5) r = 12'hABC;
            else if (ch == 3'd1 && lp_q.size() > 0)
              r = lp_q.pop_front();
            else r = {ch, 8'h00} + res_add;
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b1;
            res       = r;
            @(posedge clk);
            #1;
            cnv_cmplt = 1'b0;
          end
        end
        chk("no_strt_in_wait", 32'(bad), 0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not end by itself");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset state
    cyc(3);
    chk("rst_strt", 32'(strt_cnv), 0);
    chk("rst_chnnl", 32'(chnnl), 0);
    chk("rst_lp", 32'(LP_pot), 0);
    chk("rst_vol", 32'(VOL_pot), 0);
    chk("rst_aux_busy", 32'(aux_busy), 0);
    chk("rst_aux_vld", 32'(aux_vld), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_cnv_err", 32'(cnv_err), 0);

    // full scan, res = 0x100*chnnl
    ch_q.push_back(3'd1);
    ch_q.push_back(3'd0);
    ch_q.push_back(3'd4);
    ch_q.push_back(3'd2);
    ch_q.push_back(3'd3);
    ch_q.push_back(3'd7);
    rst_n   = 1'b1;
    scan_en = 1'b1;
    wait_sd(1, 1000, "scan1_done");
    scan_en = 1'b0;
    cyc(60);
    chk("s1_lp", 32'(LP_pot), 32'h100);
    chk("s1_b1", 32'(B1_pot), 32'h000);
    chk("s1_b2", 32'(B2_pot), 32'h400);
    chk("s1_b3", 32'(B3_pot), 32'h200);
    chk("s1_hp", 32'(HP_pot), 32'h300);
    chk("s1_vol", 32'(VOL_pot), 32'h700);
    chk("s1_done_cnt", 32'(sd_cnt), 1);
    chk("s1_strt_cnt", 32'(st_cnt), 6);

    // aux during B1, then scan off during B2
    res_add = 12'h011;
    ch_q.push_back(3'd1);
    ch_q.push_back(3'd0);
    ch_q.push_back(3'd5);
    ch_q.push_back(3'd4);
    aux_q.push_back(12'hABC);
    scan_en = 1'b1;
    wait_st(8, 400, "p2_b1_start");
    cyc(5);
    aux_ch  = 3'd5;
    aux_req = 1'b1;
    cyc(1);
    aux_req = 1'b0;
    chk("aux_busy_set", 32'(aux_busy), 1);
    cyc(2);
    aux_ch  = 3'd6;
    aux_req = 1'b1;
    cyc(1);
    aux_req = 1'b0;
    aux_ch  = 3'd0;
    chk("aux_busy_hold", 32'(aux_busy), 1);
    wait_st(10, 400, "p2_b2_start");
    cyc(2);
    scan_en = 1'b0;
    cyc(100);
    chk("p2_lp", 32'(LP_pot), 32'(filt(12'h100, 12'h111)));
    chk("p2_b1", 32'(B1_pot), 32'(filt(12'h000, 12'h011)));
    chk("p2_b2", 32'(B2_pot), 32'(filt(12'h400, 12'h411)));
    chk("p2_aux_busy_clr", 32'(aux_busy), 0);
    chk("p2_aux_vld_cnt", 32'(av_cnt), 1);
    chk("p2_aux_res_held", 32'(aux_res), 32'hABC);
    chk("p2_strt_cnt", 32'(st_cnt), 10);

    // resume at B3; HP times out
    res_add = 12'h022;
    hold_ch = 3'd3;
    hold_on = 1'b1;
    ch_q.push_back(3'd2);
    ch_q.push_back(3'd3);
    ch_q.push_back(3'd7);
    scan_en = 1'b1;
    wait_sd(2, 6000, "p3_scan_done");
    scan_en = 1'b0;
    hold_on = 1'b0;
    cyc(40);
    chk("p3_b3", 32'(B3_pot), 32'(filt(12'h200, 12'h222)));
    chk("p3_hp_kept", 32'(HP_pot), 32'h300);
    chk("p3_vol", 32'(VOL_pot), 32'(filt(12'h700, 12'h722)));
    chk("p3_cnv_err", 32'(cnv_err), 1);
    chk("p3_strt_cnt", 32'(st_cnt), 13);
    chk("p3_aux_busy", 32'(aux_busy), 0);

    // reset in the middle of an LP conversion
    res_add = 12'h000;
    ch_q.push_back(3'd1);
    scan_en = 1'b1;
    wait_st(14, 200, "p4_lp_start");
    cyc(10);
    rst_n = 1'b0;
    cyc(3);
    chk("r2_strt", 32'(strt_cnv), 0);
    chk("r2_chnnl", 32'(chnnl), 0);
    chk("r2_lp", 32'(LP_pot), 0);
    chk("r2_hp", 32'(HP_pot), 0);
    chk("r2_aux_res", 32'(aux_res), 0);
    chk("r2_cnv_err", 32'(cnv_err), 0);
    lp_q.push_back(12'h000);
    lp_q.push_back(12'hFFF);
    ch_q.push_back(3'd1);
    ch_q.push_back(3'd0);
    ch_q.push_back(3'd4);
    ch_q.push_back(3'd2);
    ch_q.push_back(3'd3);
    ch_q.push_back(3'd7);
    ch_q.push_back(3'd1);
    rst_n = 1'b1;
    wait_sd(3, 1000, "p4_scan_done");
    chk("p4_lp_first", 32'(LP_pot), 32'h000);
    chk("p4_vol", 32'(VOL_pot), 32'h700);
    wait_st(21, 200, "p4_lp2_start");
    scan_en = 1'b0;
    cyc(80);
    chk("p4_lp_second", 32'(LP_pot),
        32'(filt(12'h000, 12'hFFF)));
    chk("p4_strt_cnt", 32'(st_cnt), 21);

    chk("ch_q_empty", 32'(ch_q.size()), 0);
    chk("aux_q_empty", 32'(aux_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
